// File: rtl/bf2i_sdf_stage.sv
// -----------------------------------------------------------------------------
// bf2i_sdf_stage
//
// Radix-2 single-path delay-feedback (SDF) butterfly stage, BF2I type.
// A frame is 2*D accepted samples (D = 2**delay_log2). During the first half
// (s=0) each sample is parked in the feedback delay line and the stage emits
// what the delay line held (the differences from the previous frame). During
// the second half (s=1) the stage emits fifo_out + x and stores fifo_out - x.
//
// Handshake: in_valid qualifies in_r/in_i. There is no backpressure; every
// cycle with in_valid=1 and sync_clr=0 accepts one sample. out_valid is a
// one-cycle qualifier for out_r/out_i/out_phase, which hold their last value
// on cycles without an accepted sample.
//
// Parameters
//   in_width   : signed input sample width
//   delay_log2 : log2 of the feedback delay depth D (0..10)
//   scale_mode : 0 = bit growth, 1 = divide by 2 with round-half-up
//   out_width  : derived output width (in_width + 1 - scale_mode)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   sync_clr   : synchronous frame restart, wins over in_valid
//   in_valid   : input sample qualifier
//   in_r, in_i : signed input sample (real / imaginary)
//   out_valid  : output sample qualifier
//   out_r,out_i: signed butterfly output
//   out_phase  : s (frame half) of the sample currently on out_*
// -----------------------------------------------------------------------------
module bf2i_sdf_stage #(
    parameter int in_width   = 12,
    parameter int delay_log2 = 3,
    parameter int scale_mode = 0,
    localparam int out_width = in_width + 1 - scale_mode
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sync_clr,
    input  logic                        in_valid,
    input  logic signed [in_width-1:0]  in_r,
    input  logic signed [in_width-1:0]  in_i,
    output logic                        out_valid,
    output logic signed [out_width-1:0] out_r,
    output logic signed [out_width-1:0] out_i,
    output logic                        out_phase
);

    localparam int D  = 1 << delay_log2;
    localparam int CW = delay_log2 + 1;
    localparam int W1 = in_width + 1;

    logic [CW-1:0]                r_cnt;
    logic                         r_primed;
    logic                         r_out_valid;
    logic signed [out_width-1:0]  r_out_r;
    logic signed [out_width-1:0]  r_out_i;
    logic                         r_out_phase;

    logic signed [W1-1:0]         r_dl_r [D];
    logic signed [W1-1:0]         r_dl_i [D];

    logic                         w_s;
    logic                         w_accept;
    logic signed [W1-1:0]         w_x_r;
    logic signed [W1-1:0]         w_x_i;
    logic signed [W1-1:0]         w_fifo_r;
    logic signed [W1-1:0]         w_fifo_i;
    logic signed [W1-1:0]         w_res_r;
    logic signed [W1-1:0]         w_res_i;
    logic signed [W1-1:0]         w_wr_r;
    logic signed [W1-1:0]         w_wr_i;
    logic signed [out_width-1:0]  w_out_r;
    logic signed [out_width-1:0]  w_out_i;

    assign w_s      = r_cnt[CW-1];
    assign w_accept = in_valid & ~sync_clr;

    // One guard bit so fifo_out +/- x never overflows.
    assign w_x_r    = {in_r[in_width-1], in_r};
    assign w_x_i    = {in_i[in_width-1], in_i};

    // Oldest entry of the shift register: written D accepted samples ago.
    assign w_fifo_r = r_dl_r[D-1];
    assign w_fifo_i = r_dl_i[D-1];

    assign w_res_r  = w_s ? (w_fifo_r + w_x_r) : w_fifo_r;
    assign w_res_i  = w_s ? (w_fifo_i + w_x_i) : w_fifo_i;
    assign w_wr_r   = w_s ? (w_fifo_r - w_x_r) : w_x_r;
    assign w_wr_i   = w_s ? (w_fifo_i - w_x_i) : w_x_i;

    generate
        if (scale_mode == 0) begin : g_grow
            assign w_out_r = w_res_r;
            assign w_out_i = w_res_i;
        end else begin : g_halve
            // (r + 1) >>> 1 equals (r >>> 1) + r[0]; the sum wraps to in_width bits.
            assign w_out_r = $signed(w_res_r[W1-1:1])
                           + $signed({{(in_width-1){1'b0}}, w_res_r[0]});
            assign w_out_i = $signed(w_res_i[W1-1:1])
                           + $signed({{(in_width-1){1'b0}}, w_res_i[0]});
        end
    endgenerate

    // Delay line contents are don't-care after reset/restart, so no reset here;
    // the primed flag masks whatever stale data comes out in the first frame.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dl_r[0] <= w_wr_r;
            r_dl_i[0] <= w_wr_i;
            for (int k = 1; k < D; k++) begin
                r_dl_r[k] <= r_dl_r[k-1];
                r_dl_i[k] <= r_dl_i[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_i     <= '0;
            r_out_phase <= 1'b0;
        end else if (sync_clr) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            // Natural wrap of the CW-bit counter gives the 2D-sample frame.
            r_cnt       <= r_cnt + CW'(1);
            if (w_s) begin
                r_primed <= 1'b1;
            end
            r_out_valid <= w_s | r_primed;
            r_out_r     <= w_out_r;
            r_out_i     <= w_out_i;
            r_out_phase <= w_s;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_phase = r_out_phase;

endmodule
